// File: rtl/aes_byte_streamer.sv
// rtl/aes_byte_streamer.sv - byte-serial front end for a 128-bit block encrypt core
//
// Collects 16 plaintext bytes (first byte in the MSB position) into pt_block,
// waits CORE_WAIT cycles for the combinational/fixed-latency core, captures
// ct_block and streams it out MSB byte first.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_byte/in_valid/in_ready    plaintext byte stream (valid/ready handshake)
//   pt_block                assembled plaintext to the encrypt core
//   ct_block                ciphertext from the encrypt core
//   out_byte/out_valid/out_ready ciphertext byte stream (valid/ready handshake)
//   busy                    block in flight (not idle in LOAD with empty block)
module aes_byte_streamer #(
    parameter int CORE_WAIT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_byte,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] pt_block,
    input  logic [127:0] ct_block,
    output logic [7:0]   out_byte,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_WAIT,
        ST_SEND
    } state_t;

    // Wait counter counts down to zero inclusive, so CORE_WAIT-1 gives
    // exactly CORE_WAIT cycles spent in WAIT.
    localparam logic [3:0] WAIT_INIT = 4'(CORE_WAIT - 1);

    state_t         r_state;
    logic [3:0]     r_cnt;
    logic [3:0]     r_wait;
    logic [127:0]   r_pt;
    logic [127:0]   r_out;

    logic           w_in_xfer;
    logic           w_out_xfer;

    // in_ready is gated by rst_n so no byte can be offered as accepted
    // while reset is being applied.
    assign in_ready   = rst_n && (r_state == ST_LOAD);
    assign out_valid  = (r_state == ST_SEND);
    assign out_byte   = r_out[127:120];
    assign pt_block   = r_pt;
    assign busy       = (r_state != ST_LOAD) || (r_cnt != 4'd0);

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
            r_cnt   <= 4'd0;
            r_wait  <= 4'd0;
            r_pt    <= 128'd0;
            r_out   <= 128'd0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_in_xfer) begin
                        r_pt <= {r_pt[119:0], in_byte};
                        if (r_cnt == 4'd15) begin
                            r_cnt   <= 4'd0;
                            r_wait  <= WAIT_INIT;
                            r_state <= ST_WAIT;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_wait == 4'd0) begin
                        r_out   <= ct_block;
                        r_state <= ST_SEND;
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                ST_SEND: begin
                    if (w_out_xfer) begin
                        // Zero fill leaves out_byte at 0x00 once the block is drained.
                        r_out <= {r_out[119:0], 8'h00};
                        if (r_cnt == 4'd15) begin
                            r_cnt   <= 4'd0;
                            r_state <= ST_LOAD;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule
